// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter sharing one dpram port among NREQ requesters, with registered RAM-side outputs.
// Optional macro DPRAM_ARB_BURST_EN keeps the pointer on a requester for up to MAXBURST consecutive grants.
module dpram_port_arbiter #(
    parameter int NREQ     = 4,
    parameter int ADRW     = 8,
    parameter int DATW     = 8,
    parameter int MAXBURST = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ*ADRW-1:0] req_addr,
    input  logic [NREQ*DATW-1:0] req_wdata,
    output logic [NREQ-1:0]      req_ready,
    output logic [ADRW-1:0]      ram_address,
    output logic                 ram_wren,
    output logic [DATW-1:0]      ram_data,
    input  logic [DATW-1:0]      ram_q,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [DATW-1:0]      rsp_rdata,
    output logic                 busy
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 8 || MAXBURST < 1 || MAXBURST > 15) begin : g_param_range
        $error("dpram_port_arbiter: parameter out of range");
    end

    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  ptr_next;
    logic [IDW-1:0]  win_id;
    logic [IDW-1:0]  win_inc;
    logic            granted;
    logic            win_we;
    logic [ADRW-1:0] win_addr;
    logic [DATW-1:0] win_wdata;
    logic            s1_valid;
    logic [IDW-1:0]  s1_id;
    logic            s2_valid;
    logic [IDW-1:0]  s2_id;
    int              scan_idx;

    // Scan from rr_ptr upward (mod NREQ); the first valid requester wins.
    always_comb begin
        granted   = 1'b0;
        win_id    = rr_ptr;
        scan_idx  = 0;
        req_ready = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = (int'(rr_ptr) + k) % NREQ;
            if (!granted && req_valid[scan_idx]) begin
                granted = 1'b1;
                win_id  = IDW'(scan_idx);
            end
        end
        if (!reset_n) begin
            granted = 1'b0;
        end
        if (granted) begin
            req_ready[win_id] = 1'b1;
        end
    end

    assign win_we    = req_we[win_id];
    assign win_addr  = req_addr[win_id*ADRW +: ADRW];
    assign win_wdata = req_wdata[win_id*DATW +: DATW];
    assign win_inc   = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + IDW'(1);

`ifdef DPRAM_ARB_BURST_EN
    logic [3:0] burst_cnt;
    logic [3:0] burst_next;
    logic [3:0] burst_base;
    logic [IDW-1:0] ptr_inc;

    assign ptr_inc = (rr_ptr == IDW'(NREQ - 1)) ? '0 : rr_ptr + IDW'(1);

    // The count belongs to whoever the pointer sits on; a grant elsewhere starts a new run.
    always_comb begin
        ptr_next   = rr_ptr;
        burst_next = burst_cnt;
        burst_base = (win_id == rr_ptr) ? burst_cnt : 4'd0;
        if (granted) begin
            if (burst_base + 4'd1 >= 4'(MAXBURST)) begin
                ptr_next   = win_inc;
                burst_next = 4'd0;
            end else begin
                ptr_next   = win_id;
                burst_next = burst_base + 4'd1;
            end
        end else if (burst_cnt != 4'd0) begin
            ptr_next   = ptr_inc;
            burst_next = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            burst_cnt <= 4'd0;
        end else begin
            burst_cnt <= burst_next;
        end
    end
`else
    assign ptr_next = granted ? win_inc : rr_ptr;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_ptr      <= '0;
            ram_address <= '0;
            ram_data    <= '0;
            ram_wren    <= 1'b0;
            s1_valid    <= 1'b0;
            s1_id       <= '0;
            s2_valid    <= 1'b0;
            s2_id       <= '0;
        end else begin
            rr_ptr <= ptr_next;
            if (granted) begin
                ram_address <= win_addr;
                ram_data    <= win_wdata;
            end
            ram_wren <= granted & win_we;
            s1_valid <= granted & ~win_we;
            s1_id    <= win_id;
            s2_valid <= s1_valid;
            s2_id    <= s1_id;
        end
    end

    // Read data arrives from the RAM in the same cycle the stage-2 strobe is high.
    always_comb begin
        rsp_valid = '0;
        if (s2_valid) begin
            rsp_valid[s2_id] = 1'b1;
        end
    end

    assign rsp_rdata = ram_q;
    assign busy      = s1_valid | s2_valid | ram_wren;

endmodule
